// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RESP
    } axil_mst_state_e;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    // A zero timeout still needs a one-bit counter so the ports stay legal.
    function automatic int unsigned ctr_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/axil_timeout_ctr.sv
// Saturating transaction-age counter; expired flags the cycle whose clock edge
// would bring the count up to TIMEOUT_CYCLES (or any later cycle once saturated).
module axil_timeout_ctr
    import axil_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned   CW      = ctr_width(TIMEOUT_CYCLES);
    localparam bit            ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST    = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (ENABLED && en && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = ENABLED && en && (count_q >= LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one single-beat command in, one AXI transaction out,
// one response pulse back. Only one transaction is ever in flight.
module axil_cmd_master
    import axil_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    axil_mst_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic ctr_clear;
    logic ctr_en;
    logic expired;
    logic aw_ok;
    logic w_ok;
    logic do_timeout;

    axil_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clear),
        .en     (ctr_en),
        .expired(expired)
    );

    assign ctr_en = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_RESP);

    // A write channel counts as done once its valid has already dropped or is handshaking now.
    assign aw_ok = !awvalid_q || axi_awready;
    assign w_ok  = !wvalid_q  || axi_wready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        ctr_clear     = 1'b0;
        do_timeout    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    ctr_clear = 1'b1;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_q && axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
                if (aw_ok && w_ok) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (expired) begin
                    do_timeout = 1'b1;
                end
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    state_d       = RESP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = axi_bresp;
                    rsp_timeout_d = 1'b0;
                end else if (expired) begin
                    do_timeout = 1'b1;
                end
            end
            RD_REQ: begin
                if (axi_arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (expired) begin
                    do_timeout = 1'b1;
                end
            end
            RD_RESP: begin
                if (axi_rvalid) begin
                    state_d       = RESP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = axi_rdata;
                    rsp_resp_d    = axi_rresp;
                    rsp_timeout_d = 1'b0;
                end else if (expired) begin
                    do_timeout = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hang recovery: abandon the bus mid-phase and report a synthetic SLVERR.
        if (do_timeout) begin
            state_d       = RESP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = AXIL_RESP_SLVERR;
            rsp_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= AXIL_RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign axi_awaddr  = addr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;
    assign axi_araddr  = addr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;

endmodule
